// File: rtl/msj_pwm_bridge_driver.sv
// Signed-duty H-bridge PWM driver with per-period duty latch and dead-time
// insertion whenever the bridge direction reverses.
module msj_pwm_bridge_driver #(
    parameter int unsigned PWM_PERIOD = 2500,
    parameter int unsigned DEADTIME   = 50
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [31:0] duty,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               update_tick,
    output logic signed [31:0] duty_applied,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    localparam logic [15:0] PER     = 16'(PWM_PERIOD);
    localparam logic [15:0] LAST    = 16'(PWM_PERIOD - 1);
    localparam logic [15:0] DT_LOAD = 16'(DEADTIME - 1);

    state_t             cur, nxt;
    logic [15:0]        cnt, cnt_next;
    logic [15:0]        mag, mag_q, mag_next;
    logic [15:0]        dead_cnt, dead_next;
    logic               last_dir, last_dir_next;
    logic               target, target_next;
    logic               dir_req;
    logic [32:0]        abs_duty;
    logic signed [31:0] applied_q, applied_next;
    logic               pwm_a_next, pwm_b_next;

    assign update_tick  = (cnt == LAST);
    assign state        = cur;
    assign duty_applied = (cur == S_IDLE) ? '0 : applied_q;

    // 33-bit magnitude so that -2^31 does not overflow before saturation
    always_comb begin
        dir_req  = duty[31];
        abs_duty = duty[31] ? (33'd0 - {1'b1, duty}) : {1'b0, duty};
        mag      = (abs_duty > {17'd0, PER}) ? PER : abs_duty[15:0];
    end

    always_comb begin
        cnt_next      = update_tick ? '0 : cnt + 16'd1;
        mag_next      = update_tick ? mag : mag_q;
        nxt           = cur;
        dead_next     = dead_cnt;
        target_next   = target;
        last_dir_next = last_dir;
        applied_next  = applied_q;

        if (cur == S_DEAD) begin
            if (dead_cnt == '0) begin
                nxt           = target ? S_REV : S_FWD;
                last_dir_next = target;
            end else begin
                dead_next = dead_cnt - 16'd1;
            end
        end

        // Tick decisions override dead-time completion, except that a latch
        // repeating the pending target lets the running count continue.
        if (update_tick) begin
            applied_next = dir_req ? -$signed({16'd0, mag}) : $signed({16'd0, mag});
            if (mag == '0) begin
                nxt           = S_IDLE;
                dead_next     = '0;
                last_dir_next = last_dir;
            end else if (cur == S_DEAD && dir_req == target) begin
                nxt = nxt;
            end else if (dir_req == last_dir) begin
                nxt           = dir_req ? S_REV : S_FWD;
                dead_next     = '0;
                last_dir_next = dir_req;
            end else begin
                nxt           = S_DEAD;
                target_next   = dir_req;
                dead_next     = DT_LOAD;
                last_dir_next = last_dir;
            end
        end

        if (!enable) begin
            nxt           = S_IDLE;
            dead_next     = '0;
            last_dir_next = last_dir;
        end

        pwm_a_next = (nxt == S_FWD) && (cnt_next < mag_next);
        pwm_b_next = (nxt == S_REV) && (cnt_next < mag_next);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            mag_q     <= '0;
            dead_cnt  <= '0;
            last_dir  <= 1'b0;
            target    <= 1'b0;
            applied_q <= '0;
            pwm_a     <= 1'b0;
            pwm_b     <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_next;
            mag_q     <= mag_next;
            dead_cnt  <= dead_next;
            last_dir  <= last_dir_next;
            target    <= target_next;
            applied_q <= applied_next;
            pwm_a     <= pwm_a_next;
            pwm_b     <= pwm_b_next;
        end
    end

endmodule

// File: tb/tb_msj_pwm_bridge_driver.sv
// Scoreboard bench for msj_pwm_bridge_driver (PWM_PERIOD=100, DEADTIME=10).
module tb_msj_pwm_bridge_driver;

    localparam int P  = 100;
    localparam int DT = 10;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [31:0] duty;
    logic               pwm_a, pwm_b, update_tick;
    logic signed [31:0] duty_applied;
    logic [1:0]         state;

    msj_pwm_bridge_driver #(.PWM_PERIOD(P), .DEADTIME(DT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .duty(duty),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .update_tick(update_tick),
        .duty_applied(duty_applied), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]         st;
        logic               a;
        logic               b;
        logic               tick;
        logic signed [31:0] ap;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;
    int          gcyc     = 0;

    function automatic exp_t mk(int c, logic [1:0] st, int lo, int hi, int ap);
        exp_t e;
        e.st   = st;
        e.a    = (st == 2'd1) && (c >= lo) && (c < hi);
        e.b    = (st == 2'd2) && (c >= lo) && (c < hi);
        e.tick = (c == P - 1);
        e.ap   = (st == 2'd0) ? 32'sd0 : 32'(ap);
        return e;
    endfunction

    task automatic push_range(input int from, input int to, input logic [1:0] st,
                              input int lo, input int hi, input int ap);
        for (int c = from; c <= to; c++) q.push_back(mk(c, st, lo, hi, ap));
    endtask

    // k dead cycles, then state st with output on for counter in [k, m)
    task automatic push_period(input int k, input logic [1:0] st, input int m, input int ap);
        if (k > 0) push_range(0, k - 1, 2'd3, 0, 0, ap);
        push_range(k, P - 1, st, k, m, ap);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc  = (cyc == P - 1) ? 0 : cyc + 1;
        gcyc = gcyc + 1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        duty   = 32'sd30;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", {state, pwm_a, pwm_b, update_tick, duty_applied});
        end
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_fwd();
        exp_t e;
        push_period(0, 2'd0, 0, 0);
        push_period(0, 2'd1, 30, 30);
        push_period(0, 2'd1, 30, 30);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL fwd cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            step();
        end
    endtask

    task automatic test_reverse();
        exp_t e;
        duty = -32'sd40;
        push_period(0, 2'd1, 30, 30);
        push_period(DT, 2'd2, 40, -40);
        push_period(0, 2'd2, 40, -40);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL reverse cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        exp_t               e;
        logic signed [31:0] tbl [3];
        tbl[0] = 32'sh8000_0000;
        tbl[1] = 32'sd500;
        tbl[2] = 32'sd500;
        push_period(0, 2'd2, 40, -40);
        push_period(0, 2'd2, 100, -100);
        push_period(DT, 2'd1, 100, 100);
        push_period(0, 2'd1, 100, 100);
        for (int i = 0; q.size() > 0; i++) begin
            if (cyc == 0 && i / P < 3) duty = tbl[i / P];
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL saturation cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            step();
        end
    endtask

    task automatic test_idle();
        exp_t               e;
        logic signed [31:0] tbl [2];
        tbl[0] = 32'sd0;
        tbl[1] = 32'sd20;
        push_period(0, 2'd1, 100, 100);
        push_period(0, 2'd0, 0, 0);
        push_period(0, 2'd1, 20, 20);
        push_period(0, 2'd1, 20, 20);
        for (int i = 0; q.size() > 0; i++) begin
            if (cyc == 0 && i / P < 2) duty = tbl[i / P];
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            step();
        end
    endtask

    task automatic test_enable_dead();
        exp_t e;
        int   p;
        push_period(0, 2'd1, 20, 20);
        push_range(0, 5, 2'd3, 0, 0, -40);
        push_range(6, P - 1, 2'd0, 0, 0, 0);
        push_period(0, 2'd0, 0, 0);
        push_period(DT, 2'd2, 40, -40);
        push_range(0, 50, 2'd2, 0, 40, -40);
        push_range(51, P - 1, 2'd0, 0, 0, 0);
        push_period(0, 2'd0, 0, 0);
        push_period(0, 2'd2, 40, -40);
        for (int i = 0; q.size() > 0; i++) begin
            p = i / P;
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL enable_dead cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            if (p == 0 && cyc == 0)  duty   = -32'sd40;
            if (p == 1 && cyc == 5)  enable = 1'b0;
            if (p == 2 && cyc == 0)  enable = 1'b1;
            if (p == 4 && cyc == 50) enable = 1'b0;
            if (p == 5 && cyc == 0)  enable = 1'b1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        push_range(0, 5, 2'd2, 0, 40, -40);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", cyc, {state, pwm_a, pwm_b, update_tick, duty_applied}, e);
            end
            if (q.size() > 0) step();
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h exp=0", {state, pwm_a, pwm_b, update_tick, duty_applied});
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic test_random();
        int last_a = -1000;
        int last_b = -1000;
        int mg;
        for (int t = 0; t < 20000; t++) begin
            n_checks++;
            if (pwm_a && pwm_b) begin
                n_fail++;
                $display("FAIL random_overlap gcyc=%0d got a=1 b=1 exp not both", gcyc);
            end
            n_checks++;
            if (update_tick !== (cyc == P - 1)) begin
                n_fail++;
                $display("FAIL random_tick cyc=%0d got=%b exp=%b", cyc, update_tick, cyc == P - 1);
            end
            if (pwm_b) begin
                n_checks++;
                if (gcyc - last_a - 1 < DT) begin
                    n_fail++;
                    $display("FAIL random_gap_ab gcyc=%0d got gap=%0d exp>=%0d", gcyc, gcyc - last_a - 1, DT);
                end
                last_b = gcyc;
            end
            if (pwm_a) begin
                n_checks++;
                if (gcyc - last_b - 1 < DT) begin
                    n_fail++;
                    $display("FAIL random_gap_ba gcyc=%0d got gap=%0d exp>=%0d", gcyc, gcyc - last_b - 1, DT);
                end
                last_a = gcyc;
            end
            if ($urandom_range(0, 39) == 0) begin
                mg = int'($urandom_range(1, 120));
                case ($urandom_range(0, 4))
                    0:       duty = 32'sd0;
                    1:       duty = 32'sh8000_0000;
                    2:       duty = 32'sh7fff_ffff;
                    default: duty = $urandom_range(0, 1) ? 32'(-mg) : 32'(mg);
                endcase
            end
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 1999) == 0) begin
                reset = 1'b1;
                #1;
                n_checks++;
                if ({state, pwm_a, pwm_b, update_tick, duty_applied} !== 37'd0) begin
                    n_fail++;
                    $display("FAIL random_reset got=%h exp=0", {state, pwm_a, pwm_b, update_tick, duty_applied});
                end
                @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
                cyc   = 0;
                gcyc  = gcyc + 1;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_reverse();
        test_saturation();
        test_idle();
        test_enable_dead();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
